// File: rtl/prbs_gen_checker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_pkg
//  Purpose  : Shared types, standard PRBS tap masks and lock-up helpers for
//             the PRBS generator / checker slice.
//  Contents : chk_state_t       checker FSM state (HUNT / LOCKED)
//             PRBSn_TAPS        feedback masks for common PRBS polynomials
//             lockup_val()      state the LFSR can never leave
//             reset_val()       state used at reset and for lock-up recovery
//  Revision : 1.0  initial release
// ============================================================================
package prbs_pkg;

   typedef enum logic [0:0] {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_t;

   // Bit i set => stage i takes part in the feedback parity.
   localparam logic [6:0]  PRBS7_TAPS  = 7'h41;
   localparam logic [14:0] PRBS15_TAPS = 15'h4001;
   localparam logic [22:0] PRBS23_TAPS = 23'h000021;
   localparam logic [30:0] PRBS31_TAPS = 31'h00000009;

   // With XOR feedback the all-zero state maps onto itself; with XNOR
   // feedback the all-one state does. Result is right-aligned in 32 bits.
   function automatic logic [31:0] lockup_val(input int width, input logic xnor_mode);
      logic [31:0] ones;
      ones = (32'd1 << width) - 32'd1;
      return xnor_mode ? ones : 32'd0;
   endfunction

   // Reset value is a single 1 in stage 0 (XOR) or its complement (XNOR).
   function automatic logic [31:0] reset_val(input int width, input logic xnor_mode);
      logic [31:0] ones;
      ones = (32'd1 << width) - 32'd1;
      return xnor_mode ? (ones & ~32'd1) : 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_gen_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_gen_checker_if
//  Purpose  : Bundles the pattern-control, serial line and status signals of
//             the PRBS generator / checker.
//  Modports : master  pattern-control / line side (drives controls, rx)
//             slave   PRBS block (drives generator and checker status)
//  Revision : 1.0  initial release
// ============================================================================
interface prbs_gen_checker_if #(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 16
);
   // generator controls
   logic                 enable;
   logic                 load;
   logic [WIDTH-1:0]     seed;
   logic [WIDTH-1:0]     taps;
   logic                 xnor_mode;
   // generator outputs
   logic [WIDTH-1:0]     gen_state;
   logic                 gen_bit;
   logic                 gen_valid;
   logic                 lockup;
   // checker inputs
   logic                 rx_bit;
   logic                 rx_valid;
   logic                 err_clear;
   // checker outputs
   logic                 chk_locked;
   logic                 err_pulse;
   logic [ERR_CNT_W-1:0] err_count;

   modport master (
      output enable, load, seed, taps, xnor_mode, rx_bit, rx_valid, err_clear,
      input  gen_state, gen_bit, gen_valid, lockup, chk_locked, err_pulse, err_count
   );

   modport slave (
      input  enable, load, seed, taps, xnor_mode, rx_bit, rx_valid, err_clear,
      output gen_state, gen_bit, gen_valid, lockup, chk_locked, err_pulse, err_count
   );
endinterface
`default_nettype wire

// File: rtl/prbs_gen_checker_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_checker
//  Purpose  : Self-synchronising PRBS checker. Predicts each received bit from
//             the previous WIDTH received bits, hunts for SYNC_LEN consecutive
//             correct predictions, then counts mismatches while locked and
//             drops lock after LOSS_ERRS errors inside one SYNC_LEN window.
//  Ports    : clk, reset        clock, synchronous active-high reset
//             taps, xnor_mode   feedback mask and polarity (same as generator)
//             rx_bit, rx_valid  received serial bit and qualifier
//             err_clear         clear the error counter
//             chk_locked        checker is in LOCKED
//             err_pulse         one-cycle pulse per locked mismatch
//             err_count         saturating locked-mismatch count
//  Revision : 1.0  initial release
// ============================================================================
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 16,
   parameter int SYNC_LEN  = 32,
   parameter int LOSS_ERRS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     taps,
   input  logic                 xnor_mode,
   input  logic                 rx_bit,
   input  logic                 rx_valid,
   input  logic                 err_clear,
   output logic                 chk_locked,
   output logic                 err_pulse,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int FILL_W = $clog2(WIDTH + 1);
   localparam int SYNC_W = $clog2(SYNC_LEN + 1);
   localparam int LOSS_W = $clog2(LOSS_ERRS + 1);

   localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(WIDTH);
   localparam logic [SYNC_W-1:0]    SYNC_LAST = SYNC_W'(SYNC_LEN - 1);
   localparam logic [LOSS_W-1:0]    LOSS_LAST = LOSS_W'(LOSS_ERRS - 1);
   localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
   localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

   chk_state_t        state;
   logic [WIDTH-1:0]  hist;      // hist[0] is the oldest received bit
   logic [FILL_W-1:0] fill;
   logic [SYNC_W-1:0] match;
   logic [SYNC_W-1:0] win_bits;
   logic [LOSS_W-1:0] win_err;

   logic pred;
   logic primed;
   logic bit_err;
   logic locked_err;

   always_comb begin
      pred       = (^(hist & taps)) ^ xnor_mode;
      primed     = (fill == FILL_FULL);
      bit_err    = rx_valid && primed && (rx_bit != pred);
      locked_err = (state == LOCKED) && bit_err;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= HUNT;
         hist      <= '0;
         fill      <= '0;
         match     <= '0;
         win_bits  <= '0;
         win_err   <= '0;
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= locked_err;

         // A clear that lands on a mismatch still records that mismatch.
         if (err_clear) begin
            err_count <= locked_err ? ERR_ONE : '0;
         end else if (locked_err && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_ONE;
         end

         if (rx_valid) begin
            hist <= {rx_bit, hist[WIDTH-1:1]};
            if (!primed) begin
               fill <= fill + FILL_W'(1);
            end

            case (state)
               HUNT: begin
                  if (primed) begin
                     if (rx_bit == pred) begin
                        if (match == SYNC_LAST) begin
                           state    <= LOCKED;
                           match    <= '0;
                           win_bits <= '0;
                           win_err  <= '0;
                        end else begin
                           match <= match + SYNC_W'(1);
                        end
                     end else begin
                        match <= '0;
                     end
                  end
               end
               LOCKED: begin
                  // Loss of lock wins over the window rollover so the last
                  // bit of a window can still drop lock.
                  if (bit_err && (win_err == LOSS_LAST)) begin
                     state    <= HUNT;
                     fill     <= '0;
                     match    <= '0;
                     win_bits <= '0;
                     win_err  <= '0;
                  end else if (win_bits == SYNC_LAST) begin
                     win_bits <= '0;
                     win_err  <= '0;
                  end else begin
                     win_bits <= win_bits + SYNC_W'(1);
                     if (bit_err) begin
                        win_err <= win_err + LOSS_W'(1);
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

   assign chk_locked = (state == LOCKED);

endmodule
`default_nettype wire

// File: rtl/prbs_gen_checker.sv
`default_nettype none
// ============================================================================
//  Module   : prbs_gen_checker
//  Purpose  : PRBS pattern generator (Fibonacci LFSR, runtime taps, XOR/XNOR
//             feedback, seed load, lock-up recovery) plus an independent
//             self-synchronising checker for the received stream.
//  Ports    : clk    clock
//             reset  synchronous active-high reset
//             bus    prbs_gen_checker_if.slave: generator controls/outputs,
//                    rx bit/valid, err_clear and checker status
//  Revision : 1.0  initial release
// ============================================================================
module prbs_gen_checker
   import prbs_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ERR_CNT_W = 16,
   parameter int SYNC_LEN  = 32,
   parameter int LOSS_ERRS = 4
) (
   input  logic               clk,
   input  logic               reset,
   prbs_gen_checker_if.slave  bus
);

   localparam logic [WIDTH-1:0] LOCKUP_XOR  = WIDTH'(lockup_val(WIDTH, 1'b0));
   localparam logic [WIDTH-1:0] LOCKUP_XNOR = WIDTH'(lockup_val(WIDTH, 1'b1));
   localparam logic [WIDTH-1:0] RESET_XOR   = WIDTH'(reset_val(WIDTH, 1'b0));
   localparam logic [WIDTH-1:0] RESET_XNOR  = WIDTH'(reset_val(WIDTH, 1'b1));

   logic [WIDTH-1:0] gen_state;
   logic             gen_bit;
   logic             gen_valid;
   logic             lockup;

   logic [WIDTH-1:0] lockup_state;
   logic [WIDTH-1:0] reset_state;
   logic [WIDTH-1:0] next_state;
   logic             fb;

   always_comb begin
      lockup_state = bus.xnor_mode ? LOCKUP_XNOR : LOCKUP_XOR;
      reset_state  = bus.xnor_mode ? RESET_XNOR  : RESET_XOR;
      fb           = (^(gen_state & bus.taps)) ^ bus.xnor_mode;
      next_state   = {fb, gen_state[WIDTH-1:1]};
   end

   // Load has priority over enable. A lock-up state, whether reached by a
   // step or loaded as a seed, is replaced by the reset value so the LFSR
   // can never stall.
   always_ff @(posedge clk) begin
      if (reset) begin
         gen_state <= reset_state;
         gen_bit   <= 1'b0;
         gen_valid <= 1'b0;
         lockup    <= 1'b0;
      end else begin
         gen_valid <= 1'b0;
         lockup    <= 1'b0;
         if (bus.load) begin
            if (bus.seed == lockup_state) begin
               gen_state <= reset_state;
               lockup    <= 1'b1;
            end else begin
               gen_state <= bus.seed;
            end
         end else if (bus.enable) begin
            gen_bit   <= gen_state[0];
            gen_valid <= 1'b1;
            if (gen_state == lockup_state) begin
               gen_state <= reset_state;
               lockup    <= 1'b1;
            end else begin
               gen_state <= next_state;
            end
         end
      end
   end

   assign bus.gen_state = gen_state;
   assign bus.gen_bit   = gen_bit;
   assign bus.gen_valid = gen_valid;
   assign bus.lockup    = lockup;

   prbs_checker #(
      .WIDTH     (WIDTH),
      .ERR_CNT_W (ERR_CNT_W),
      .SYNC_LEN  (SYNC_LEN),
      .LOSS_ERRS (LOSS_ERRS)
   ) u_checker (
      .clk        (clk),
      .reset      (reset),
      .taps       (bus.taps),
      .xnor_mode  (bus.xnor_mode),
      .rx_bit     (bus.rx_bit),
      .rx_valid   (bus.rx_valid),
      .err_clear  (bus.err_clear),
      .chk_locked (bus.chk_locked),
      .err_pulse  (bus.err_pulse),
      .err_count  (bus.err_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_prbs_gen_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prbs_gen_checker
//  Purpose  : Directed self-checking bench. Instance A (WIDTH=4) exercises
//             the generator; instance B (WIDTH=7, PRBS7, 3-bit error counter)
//             loops its generator output back into its checker with an
//             optional bit inversion.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prbs_gen_checker;
   import prbs_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic flip;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   rxn    = 0;   // bits accepted by checker B since time zero
   int   pulses = 0;   // err_pulse cycles seen on checker B

   always #5 clk = ~clk;

   prbs_gen_checker_if #(.WIDTH(4), .ERR_CNT_W(16)) ifa ();
   prbs_gen_checker_if #(.WIDTH(7), .ERR_CNT_W(3))  ifb ();

   prbs_gen_checker #(.WIDTH(4), .ERR_CNT_W(16), .SYNC_LEN(32), .LOSS_ERRS(4)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa.slave)
   );

   prbs_gen_checker #(.WIDTH(7), .ERR_CNT_W(3), .SYNC_LEN(32), .LOSS_ERRS(4)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb.slave)
   );

   assign ifb.rx_bit   = ifb.gen_bit ^ flip;
   assign ifb.rx_valid = ifb.gen_valid;

   always @(posedge clk) if (ifb.rx_valid) rxn <= rxn + 1;
   always @(negedge clk) if (ifb.err_pulse) pulses = pulses + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_cmp++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, want);
      end
   endtask

   task automatic run_to(input int target);
      int guard = 0;
      while (rxn < target && guard < 5000) begin
         @(negedge clk);
         guard++;
      end
      n_cmp++;
      assert (rxn == target) else begin
         n_fail++;
         $error("FAIL run_to: observed %0d bits expected %0d", rxn, target);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // W=4, taps 0011 from 0001: states after each step and emitted bits.
   logic [3:0]  seq_a [15] = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
                               4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};
   logic        bit_a [15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

   initial begin
      reset = 1'b1;
      flip  = 1'b0;
      ifa.enable = 1'b0; ifa.load = 1'b0; ifa.seed = '0; ifa.taps = 4'b0011;
      ifa.xnor_mode = 1'b0; ifa.rx_bit = 1'b0; ifa.rx_valid = 1'b0; ifa.err_clear = 1'b0;
      ifb.enable = 1'b0; ifb.load = 1'b0; ifb.seed = '0; ifb.taps = PRBS7_TAPS;
      ifb.xnor_mode = 1'b0; ifb.err_clear = 1'b0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_a_state", ifa.gen_state, 32'h1);
      check("rst_a_valid", ifa.gen_valid, 32'h0);
      check("rst_a_lockup", ifa.lockup, 32'h0);
      check("rst_b_state", ifb.gen_state, 32'h01);
      check("rst_b_locked", ifb.chk_locked, 32'h0);
      check("rst_b_errcnt", ifb.err_count, 32'h0);
      check("rst_b_errpulse", ifb.err_pulse, 32'h0);
      reset = 1'b0;

      // 1: full period of the 4-stage LFSR
      ifa.load = 1'b1; ifa.seed = 4'h1;
      @(negedge clk);
      check("load_state", ifa.gen_state, 32'h1);
      check("load_novalid", ifa.gen_valid, 32'h0);
      ifa.load = 1'b0; ifa.enable = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         check($sformatf("step%0d_state", i), ifa.gen_state, 32'(seq_a[i]));
         check($sformatf("step%0d_bit", i), ifa.gen_bit, 32'(bit_a[i]));
         check($sformatf("step%0d_valid", i), ifa.gen_valid, 32'h1);
      end
      ifa.enable = 1'b0;
      @(negedge clk);
      check("idle_valid", ifa.gen_valid, 32'h0);
      check("idle_state", ifa.gen_state, 32'h1);

      // 2: lock-up seeds, load priority over enable
      ifa.load = 1'b1; ifa.seed = 4'h0; ifa.enable = 1'b1;
      @(negedge clk);
      check("xor_lk_state", ifa.gen_state, 32'h1);
      check("xor_lk_valid", ifa.gen_valid, 32'h0);
      check("xor_lk_pulse", ifa.lockup, 32'h1);
      ifa.load = 1'b0; ifa.enable = 1'b0;
      @(negedge clk);
      check("xor_lk_once", ifa.lockup, 32'h0);
      ifa.xnor_mode = 1'b1; ifa.load = 1'b1; ifa.seed = 4'hF;
      @(negedge clk);
      check("xnor_lk_state", ifa.gen_state, 32'hE);
      check("xnor_lk_pulse", ifa.lockup, 32'h1);
      ifa.load = 1'b0; ifa.enable = 1'b1;
      @(negedge clk);
      check("xnor_lk_once", ifa.lockup, 32'h0);
      check("xnor_step_state", ifa.gen_state, 32'h7);
      check("xnor_step_bit", ifa.gen_bit, 32'h0);
      // lock-up reached by a step: F is legal under XOR, stuck under XNOR
      ifa.enable = 1'b0; ifa.xnor_mode = 1'b0; ifa.load = 1'b1; ifa.seed = 4'hF;
      @(negedge clk);
      check("seedF_xor_state", ifa.gen_state, 32'hF);
      check("seedF_xor_nolk", ifa.lockup, 32'h0);
      ifa.load = 1'b0; ifa.xnor_mode = 1'b1; ifa.enable = 1'b1;
      @(negedge clk);
      check("steplk_state", ifa.gen_state, 32'hE);
      check("steplk_bit", ifa.gen_bit, 32'h1);
      check("steplk_valid", ifa.gen_valid, 32'h1);
      check("steplk_pulse", ifa.lockup, 32'h1);
      ifa.enable = 1'b0; ifa.xnor_mode = 1'b0;

      // 3: loopback lock after 7 fill + 32 matches, clean run
      ifb.enable = 1'b1;
      run_to(38);
      check("prelock", ifb.chk_locked, 32'h0);
      run_to(39);
      check("lock", ifb.chk_locked, 32'h1);
      run_to(1063);
      check("clean_errcnt", ifb.err_count, 32'h0);
      check("clean_locked", ifb.chk_locked, 32'h1);
      check("clean_pulses", 32'(pulses), 32'h0);

      // 4: single line error -> 3 mismatches
      flip = 1'b1;
      run_to(1064);
      flip = 1'b0;
      check("single_pulse", ifb.err_pulse, 32'h1);
      run_to(1095);
      check("single_errcnt", ifb.err_count, 32'h3);
      check("single_locked", ifb.chk_locked, 32'h1);
      check("single_pulses", 32'(pulses), 32'h3);

      // 6a: clear coinciding with a mismatch
      flip = 1'b1; ifb.err_clear = 1'b1;
      run_to(1096);
      flip = 1'b0; ifb.err_clear = 1'b0;
      check("clr_mis_errcnt", ifb.err_count, 32'h1);
      run_to(1126);
      check("clr_after_errcnt", ifb.err_count, 32'h3);
      ifb.err_clear = 1'b1;
      run_to(1127);
      ifb.err_clear = 1'b0;
      check("clr_errcnt", ifb.err_count, 32'h0);

      // 5: 8 inverted bits -> mismatches at +1,+8,+10,+11 -> loss
      flip = 1'b1;
      run_to(1135);
      flip = 1'b0;
      run_to(1137);
      check("inv_locked", ifb.chk_locked, 32'h1);
      check("inv_errcnt", ifb.err_count, 32'h3);
      run_to(1138);
      check("loss_locked", ifb.chk_locked, 32'h0);
      check("loss_errcnt", ifb.err_count, 32'h4);
      // error while hunting: resets match, never counted
      run_to(1149);
      flip = 1'b1;
      run_to(1150);
      flip = 1'b0;
      check("hunt_nopulse", ifb.err_pulse, 32'h0);
      run_to(1188);
      check("hunt_locked", ifb.chk_locked, 32'h0);
      check("hunt_errcnt", ifb.err_count, 32'h4);
      run_to(1189);
      check("relock", ifb.chk_locked, 32'h1);

      // 6b: saturation of the 3-bit counter
      flip = 1'b1;
      run_to(1190);
      flip = 1'b0;
      run_to(1196);
      check("sat_pre", ifb.err_count, 32'h6);
      run_to(1221);
      check("sat_full", ifb.err_count, 32'h7);
      flip = 1'b1;
      run_to(1222);
      flip = 1'b0;
      run_to(1253);
      check("sat_hold", ifb.err_count, 32'h7);
      check("sat_locked", ifb.chk_locked, 32'h1);
      check("sat_pulses", 32'(pulses), 32'd16);

      // reset while locked
      reset = 1'b1;
      @(negedge clk);
      check("mid_rst_state", ifb.gen_state, 32'h01);
      check("mid_rst_bit", ifb.gen_bit, 32'h0);
      check("mid_rst_valid", ifb.gen_valid, 32'h0);
      check("mid_rst_lockup", ifb.lockup, 32'h0);
      check("mid_rst_locked", ifb.chk_locked, 32'h0);
      check("mid_rst_pulse", ifb.err_pulse, 32'h0);
      check("mid_rst_errcnt", ifb.err_count, 32'h0);
      reset = 1'b0;
      ifb.enable = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
